// File: rtl/game_timer_if.sv
// Gameplay-side bundle for game_timer: level/bonus/pause controls in, M:SS display and status out.
interface game_timer_if;
  logic       game_on;
  logic [1:0] level_sel;
  logic       bonus_add;
  logic       pause;
  logic       one_sec_pulse;
  logic       timer_ended;
  logic [3:0] min_digit;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       low_time;

  modport master (
    output game_on, level_sel, bonus_add, pause,
    input  one_sec_pulse, timer_ended, min_digit, sec_tens, sec_ones, low_time
  );

  modport slave (
    input  game_on, level_sel, bonus_add, pause,
    output one_sec_pulse, timer_ended, min_digit, sec_tens, sec_ones, low_time
  );
endinterface

// File: rtl/game_timer.sv
// Per-level countdown timer with BCD M:SS display, bonus pickups and a free-running 1 s tick.
// Optional macro GAME_TIMER_PAUSE_EN: when defined, pause=1 freezes the countdown in RUN.
module game_timer #(
  parameter int unsigned CLK_HZ     = 31500000,
  parameter int unsigned LEVEL1_SEC = 180,
  parameter int unsigned LEVEL2_SEC = 150,
  parameter int unsigned BONUS_SEC  = 15
) (
  input  logic         clk,
  input  logic         resetN,
  game_timer_if.slave  bus
);

  localparam int unsigned PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned SW      = 10;
  localparam logic [PW-1:0] PS_MAX  = PW'(CLK_HZ - 1);
  localparam logic [SW-1:0] MAX_SEC = SW'(599);
  localparam logic [SW-1:0] LOW_SEC = SW'(10);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ps_q, ps_d;
  logic          pulse_q, pulse_d;
  logic          game_on_q;
  logic [SW-1:0] secs_q, secs_d;
  logic          ended_q, ended_d;
  logic [11:0]   bcd_q, bcd_d;
  logic          low_q, low_d;

  logic          rise_c;
  logic          dec_c;
  logic [SW-1:0] budget_c;
  logic [31:0]   sum_c;
  logic [SW-1:0] upd_c;

  // Binary seconds -> {minutes, tens of seconds, ones of seconds}
  function automatic logic [11:0] to_bcd(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = s % SW'(60);
    return {4'(s / SW'(60)), 4'(r / SW'(10)), 4'(r % SW'(10))};
  endfunction

  assign rise_c   = bus.game_on & ~game_on_q;
  assign budget_c = (bus.level_sel == 2'd2) ? SW'(LEVEL2_SEC) : SW'(LEVEL1_SEC);

`ifdef GAME_TIMER_PAUSE_EN
  assign dec_c = pulse_q & ~bus.pause;
`else
  logic unused_pause;
  assign unused_pause = bus.pause;
  assign dec_c        = pulse_q;
`endif

  // Bonus and tick combine into one net adjustment, then clamp at 9:59
  assign sum_c = 32'(secs_q) + (bus.bonus_add ? 32'(BONUS_SEC) : 32'd0) - (dec_c ? 32'd1 : 32'd0);
  assign upd_c = (sum_c > 32'(MAX_SEC)) ? MAX_SEC : SW'(sum_c);

  always_comb begin
    state_d = state_q;
    secs_d  = secs_q;
    ended_d = ended_q;
    pulse_d = (ps_q == PS_MAX);
    ps_d    = (ps_q == PS_MAX) ? '0 : ps_q + PW'(1);

    unique case (state_q)
      IDLE: begin
        // Load edge never decrements, whatever the tick is doing
        if (rise_c) begin
          secs_d  = budget_c;
          state_d = RUN;
          ended_d = 1'b0;
        end
      end
      RUN: begin
        if (!bus.game_on) begin
          state_d = IDLE;
        end else if (dec_c || bus.bonus_add) begin
          secs_d = upd_c;
          if (upd_c == '0) begin
            state_d = EXPIRED;
            ended_d = 1'b1;
          end
        end
      end
      EXPIRED: begin
        secs_d  = '0;
        ended_d = 1'b1;
        if (!bus.game_on) begin
          state_d = IDLE;
          ended_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    bcd_d = to_bcd(secs_d);
    low_d = (state_d == RUN) && (secs_d <= LOW_SEC);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      ps_q      <= '0;
      pulse_q   <= 1'b0;
      game_on_q <= 1'b0;
      secs_q    <= '0;
      ended_q   <= 1'b0;
      bcd_q     <= '0;
      low_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ps_q      <= ps_d;
      pulse_q   <= pulse_d;
      game_on_q <= bus.game_on;
      secs_q    <= secs_d;
      ended_q   <= ended_d;
      bcd_q     <= bcd_d;
      low_q     <= low_d;
    end
  end

  assign bus.one_sec_pulse = pulse_q;
  assign bus.timer_ended   = ended_q;
  assign bus.min_digit     = bcd_q[11:8];
  assign bus.sec_tens      = bcd_q[7:4];
  assign bus.sec_ones      = bcd_q[3:0];
  assign bus.low_time      = low_q;

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer: two instances (short and near-max budgets) checked every cycle against a seconds-level model.
module tb_game_timer;

  localparam int CLK_HZ = 10;
  localparam int LVL2   = 2;
  localparam int BONUS  = 5;
  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_EXP  = 2;
`ifdef GAME_TIMER_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic clk;
  logic resetN;

  game_timer_if a_if ();
  game_timer_if b_if ();

  game_timer #(.CLK_HZ(CLK_HZ), .LEVEL1_SEC(3), .LEVEL2_SEC(LVL2), .BONUS_SEC(BONUS)) dut_a (
    .clk(clk), .resetN(resetN), .bus(a_if)
  );
  game_timer #(.CLK_HZ(CLK_HZ), .LEVEL1_SEC(598), .LEVEL2_SEC(LVL2), .BONUS_SEC(BONUS)) dut_b (
    .clk(clk), .resetN(resetN), .bus(b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_total = 0;
  int    n_bad   = 0;
  string nm[2]   = '{"a", "b"};
  int    l1[2]   = '{3, 598};

  bit       in_gon[2];
  bit [1:0] in_lvl[2];
  bit       in_bon[2];
  bit       in_pau[2];

  int m_cyc;
  bit m_pulse;
  int m_phase[2];
  int m_secs[2];
  bit m_end[2];
  bit m_gon_d[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, m_cyc);
    end
  endtask

  function automatic logic [31:0] bcd_of(input int s);
    return 32'(((s / 60) << 8) | (((s % 60) / 10) << 4) | (s % 10));
  endfunction

  task automatic apply();
    a_if.game_on   = in_gon[0];
    a_if.level_sel = in_lvl[0];
    a_if.bonus_add = in_bon[0];
    a_if.pause     = in_pau[0];
    b_if.game_on   = in_gon[1];
    b_if.level_sel = in_lvl[1];
    b_if.bonus_add = in_bon[1];
    b_if.pause     = in_pau[1];
  endtask

  task automatic get_out(input int d, output logic [31:0] p, output logic [31:0] e,
                         output logic [31:0] t, output logic [31:0] l);
    if (d == 0) begin
      p = 32'(a_if.one_sec_pulse);
      e = 32'(a_if.timer_ended);
      t = {20'd0, a_if.min_digit, a_if.sec_tens, a_if.sec_ones};
      l = 32'(a_if.low_time);
    end else begin
      p = 32'(b_if.one_sec_pulse);
      e = 32'(b_if.timer_ended);
      t = {20'd0, b_if.min_digit, b_if.sec_tens, b_if.sec_ones};
      l = 32'(b_if.low_time);
    end
  endtask

  task automatic model_reset();
    m_cyc   = 0;
    m_pulse = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = P_IDLE;
      m_secs[d]  = 0;
      m_end[d]   = 1'b0;
      m_gon_d[d] = 1'b0;
    end
  endtask

  // Reference behaviour for one rising edge, using the inputs presented to it
  task automatic model_edge();
    bit was_pulse;
    bit rise;
    bit dec;
    int t;
    was_pulse = m_pulse;
    m_cyc++;
    m_pulse = (m_cyc % CLK_HZ == 0);
    for (int d = 0; d < 2; d++) begin
      rise = in_gon[d] && !m_gon_d[d];
      m_gon_d[d] = in_gon[d];
      case (m_phase[d])
        P_IDLE: if (rise) begin
          m_secs[d]  = (in_lvl[d] == 2'd2) ? LVL2 : l1[d];
          m_phase[d] = P_RUN;
          m_end[d]   = 1'b0;
        end
        P_RUN: if (!in_gon[d]) begin
          m_phase[d] = P_IDLE;
        end else begin
          dec = was_pulse && !(PAUSE_EN && in_pau[d]);
          if (dec || in_bon[d]) begin
            t = m_secs[d] + (in_bon[d] ? BONUS : 0) - (dec ? 1 : 0);
            if (t > 599) t = 599;
            m_secs[d] = t;
            if (t == 0) begin
              m_phase[d] = P_EXP;
              m_end[d]   = 1'b1;
            end
          end
        end
        default: if (!in_gon[d]) begin
          m_phase[d] = P_IDLE;
          m_end[d]   = 1'b0;
        end
      endcase
    end
  endtask

  task automatic compare(input int d);
    logic [31:0] p, e, t, l;
    get_out(d, p, e, t, l);
    check($sformatf("%s.pulse", nm[d]), p, 32'(m_pulse));
    check($sformatf("%s.ended", nm[d]), e, 32'(m_end[d]));
    check($sformatf("%s.time", nm[d]), t, bcd_of(m_secs[d]));
    check($sformatf("%s.low", nm[d]), l, 32'(m_phase[d] == P_RUN && m_secs[d] <= 10));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare(0);
    compare(1);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    logic [31:0] p, e, t, l;
    @(negedge clk);
    resetN = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      get_out(d, p, e, t, l);
      check($sformatf("%s.rst_pulse", nm[d]), p, 32'd0);
      check($sformatf("%s.rst_ended", nm[d]), e, 32'd0);
      check($sformatf("%s.rst_time", nm[d]), t, 32'd0);
      check($sformatf("%s.rst_low", nm[d]), l, 32'd0);
    end
    model_reset();
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic check_dir(input string tag, input int d, input int secs, input int ended, input int low);
    logic [31:0] p, e, t, l;
    get_out(d, p, e, t, l);
    check({tag, ".time"}, t, bcd_of(secs));
    check({tag, ".ended"}, e, 32'(ended));
    check({tag, ".low"}, l, 32'(low));
  endtask

  initial begin
    logic [31:0] p, e, t, l;
    resetN = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_gon[d] = 1'b0; in_lvl[d] = 2'd0; in_bon[d] = 1'b0; in_pau[d] = 1'b0;
    end
    apply();
    model_reset();
    do_reset();

    // Free-running tick with gameplay idle
    for (int k = 1; k <= 30; k++) begin
      step();
      get_out(0, p, e, t, l);
      check("tick", p, 32'(k % 10 == 0));
    end
    check_dir("idle", 0, 0, 0, 0);

    // Level 1 load on a tick cycle, count down to expiry
    in_gon[0] = 1'b1; in_lvl[0] = 2'd1; apply();
    step();
    check_dir("load1", 0, 3, 0, 1);
    run(9);
    check_dir("pre_dec", 0, 3, 0, 1);
    step();
    check_dir("dec1", 0, 2, 0, 1);
    run(20);
    check_dir("expired", 0, 0, 1, 0);
    in_gon[0] = 1'b0; apply();
    step();
    check_dir("exp_exit", 0, 0, 0, 0);

    // Level 2 with a bonus coinciding with the tick
    in_gon[0] = 1'b1; in_lvl[0] = 2'd2; apply();
    step();
    check_dir("load2", 0, 2, 0, 1);
    run(7);
    in_bon[0] = 1'b1; apply();
    step();
    check_dir("bonus_tick", 0, 6, 0, 1);
    in_bon[0] = 1'b0; in_gon[0] = 1'b0; apply();
    step();

    // Drop mid-run freezes digits; re-raise reloads
    in_gon[0] = 1'b1; in_lvl[0] = 2'd1; apply();
    step();
    check_dir("reload_a", 0, 3, 0, 1);
    run(8);
    check_dir("run1s", 0, 2, 0, 1);
    in_gon[0] = 1'b0; apply();
    step();
    check_dir("frozen", 0, 2, 0, 0);
    in_gon[0] = 1'b1; apply();
    step();
    check_dir("reload_b", 0, 3, 0, 1);

    // Pause across two ticks
    in_pau[0] = 1'b1; apply();
    run(18);
    check_dir("pause", 0, PAUSE_EN ? 3 : 1, 0, 1);
    in_pau[0] = 1'b0; in_gon[0] = 1'b0; apply();
    step();

    // Saturation and minute borrow on the long-budget instance
    in_gon[1] = 1'b1; in_lvl[1] = 2'd1; apply();
    step();
    check_dir("b_load", 1, 598, 0, 0);
    in_bon[1] = 1'b1; apply();
    step();
    check_dir("b_sat", 1, 599, 0, 0);
    in_bon[1] = 1'b0; apply();
    run(7);
    check_dir("b_dec", 1, 598, 0, 0);
    run(5380);
    check_dir("b_1min", 1, 60, 0, 0);
    run(10);
    check_dir("b_borrow", 1, 59, 0, 0);
    in_gon[1] = 1'b0; apply();
    step();

    // Reset while running, game_on held high: next edge reloads
    in_gon[0] = 1'b1; in_lvl[0] = 2'd0; apply();
    run(14);
    do_reset();
    step();
    check_dir("rst_reload", 0, 3, 0, 1);

    // Randomised gameplay
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(39) == 0) in_gon[d] = !in_gon[d];
        if ($urandom_range(15) == 0) in_lvl[d] = 2'($urandom_range(3));
        in_bon[d] = ($urandom_range(7) == 0);
        in_pau[d] = ($urandom_range(3) == 0);
      end
      apply();
      if (i == 1500) do_reset();
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 31500000, clock cycles per second.
REQ-002 SHALL have parameter LEVEL1_SEC, default 180, level-1 time budget in seconds (legal range 1..599).
REQ-003 SHALL have parameter LEVEL2_SEC, default 150, level-2 time budget in seconds (legal range 1..599).
REQ-004 SHALL have parameter BONUS_SEC, default 15, seconds added per bonus pickup.
REQ-005 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port resetN  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port game_on  in  1  gameplay active, level from game state machine.
REQ-008 SHALL have port level_sel  in  2  current level; 2 selects LEVEL2_SEC, any other value selects LEVEL1_SEC.
REQ-009 SHALL have port bonus_add  in  1  one-cycle pulse, time-bonus pickup.
REQ-010 SHALL have port pause  in  1  level, freeze countdown (see Configuration).
REQ-011 SHALL have port one_sec_pulse  out  1  free-running one-cycle pulse, once per second.
REQ-012 SHALL have port timer_ended  out  1  level, countdown reached 0:00.
REQ-013 SHALL have ports min_digit, sec_tens, sec_ones  out  4 each  remaining time as BCD M:SS.
REQ-014 SHALL have port low_time  out  1  high in RUN while remaining time <= 10 s.

Function
REQ-015 SHALL count a prescaler 0..CLK_HZ-1 continuously, regardless of state and game_on.
REQ-016 SHALL assert one_sec_pulse for exactly one cycle per prescaler wrap; first pulse in the CLK_HZ-th cycle after resetN deasserts.
REQ-017 SHALL register game_on into game_on_d; a rise is game_on=1 and game_on_d=0.
REQ-018 SHALL implement states IDLE, RUN, EXPIRED.
REQ-019 SHALL, in IDLE on a rise, load digits with the budget selected by level_sel, enter RUN, and clear timer_ended.
REQ-020 SHALL NOT decrement on the load edge, even if one_sec_pulse is high.
REQ-021 SHALL, in RUN when one_sec_pulse=1, decrement M:SS by one second with BCD borrow (x:00 -> (x-1):59); the update is visible one cycle after the pulse.
REQ-022 SHALL, in RUN when the decrement reaches 0:00, enter EXPIRED and set timer_ended on the same edge.
REQ-023 SHALL, in RUN when bonus_add=1, add BONUS_SEC, saturating at 9:59.
REQ-024 SHALL, when bonus_add and one_sec_pulse coincide in RUN, apply a net +(BONUS_SEC-1), saturating at 9:59.
REQ-025 SHALL ignore bonus_add in IDLE and EXPIRED.
REQ-026 SHALL hold timer_ended=1 and digits at 0:00 in EXPIRED until game_on=0, then return to IDLE and clear timer_ended.
REQ-027 SHALL return to IDLE when game_on falls in RUN, freezing the digits for display.
REQ-028 SHALL drive low_time=1 only in RUN with remaining time <= 0:10; 0 otherwise.
REQ-029 SHALL register all outputs.

Reset
REQ-030 SHALL, on resetN=0, asynchronously set state=IDLE, prescaler=0, game_on_d=0, one_sec_pulse=0, timer_ended=0, low_time=0, and all digits=0.
REQ-031 SHALL, on reset mid-RUN or in EXPIRED, abandon the count; after release the next rise reloads the budget.

Configuration
REQ-032 SHALL support macro GAME_TIMER_PAUSE_EN.
REQ-033 SHALL, with GAME_TIMER_PAUSE_EN defined, suppress decrements while pause=1 in RUN; the prescaler, one_sec_pulse and bonus_add remain active.
REQ-034 SHALL, with GAME_TIMER_PAUSE_EN undefined, keep port pause present but ignore it.

Verification (CLK_HZ=10, LEVEL1_SEC=3, LEVEL2_SEC=2, BONUS_SEC=5)
REQ-035 SHALL check: release reset, hold game_on=0 -> one_sec_pulse high at cycle 10, 20, 30, each 1 cycle wide; digits stay 0:00.
REQ-036 SHALL check: level_sel=1, raise game_on -> 0:03 loaded; after 3 pulses timer_ended=1, 0:00, state EXPIRED; drop game_on -> timer_ended=0 next cycle.
REQ-037 SHALL check: level_sel=2 rise -> 0:02; bonus_add coincident with the first pulse -> 0:06; low_time=1 throughout.
REQ-038 SHALL check: load 0:03, run 1 s, drop game_on -> digits frozen at 0:02, IDLE; re-raise -> 0:03 reloaded.
REQ-039 SHALL check: with GAME_TIMER_PAUSE_EN, pause=1 across 2 pulses -> digits unchanged; without the macro -> 2 decrements.
REQ-040 SHALL check: LEVEL1_SEC=598, bonus_add in RUN -> 9:59 (saturated); pulse -> 9:58; next pulse from 1:00 -> 0:59.
